// File: rtl/barrier_init_writer_if.sv
// Generator lookup and arbitrated BRAM write port used by the barrier init sequencer.
interface barrier_init_writer_if;
  logic        grant_in;
  logic [15:0] gen_addr_out;
  logic        gen_data_in;
  logic        bram_we_out;
  logic [15:0] bram_addr_out;
  logic        bram_data_out;

  modport master (
    input  grant_in, gen_data_in,
    output gen_addr_out, bram_we_out, bram_addr_out, bram_data_out
  );

  modport slave (
    output grant_in, gen_data_in,
    input  gen_addr_out, bram_we_out, bram_addr_out, bram_data_out
  );
endinterface

// File: rtl/barrier_init_writer.sv
// Sweeps every lattice cell through the barrier generator and writes each flag to
// the barrier BRAM, in address order, through a small skid FIFO.
//
// state   | meaning
// S_IDLE  | waiting for start_in; count holds last sweep result
// S_SWEEP | issuing addresses 0..N-1 to the generator
// S_DRAIN | all issued; flushing in-flight results and FIFO
// S_DONE  | one-cycle completion pulse
module barrier_init_writer #(
  parameter int unsigned GRID_W      = 320,
  parameter int unsigned GRID_H      = 180,
  parameter int unsigned GEN_LATENCY = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  barrier_init_writer_if.master bus,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [15:0]           barrier_count_out
);
  localparam int unsigned N         = GRID_W * GRID_H;
  localparam logic [15:0] LAST_ADDR = 16'(N - 1);
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PIPE_D    = (GEN_LATENCY > 0) ? GEN_LATENCY : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [15:0]      issue_cnt_q, issue_cnt_d;
  logic [15:0]      count_q, count_d;
  logic [PIPE_D-1:0] pipe_vld_q, pipe_vld_d;
  logic [15:0]      pipe_addr_q [PIPE_D];
  logic [15:0]      fifo_addr_q [FIFO_DEPTH];
  logic             fifo_flag_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] in_flight, in_flight_d;
  logic [CNT_W:0]   committed;
  logic             issue, push, pop, fifo_empty, head_flag;
  logic [15:0]      push_addr;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign head_flag  = fifo_flag_q[rd_ptr_q];
  assign pop        = bus.grant_in && !fifo_empty;
  // An entry popped this edge is free for a result arriving later, so crediting
  // it keeps one issue per cycle when the pipe is full.
  assign committed  = {1'b0, in_flight} + {1'b0, fifo_cnt_q} - {{CNT_W{1'b0}}, pop};
  assign issue      = (state_q == S_SWEEP) && bus.grant_in && (committed < DEPTH_C);
  assign push       = (GEN_LATENCY == 0) ? issue : pipe_vld_q[PIPE_D-1];
  assign push_addr  = (GEN_LATENCY == 0) ? issue_cnt_q : pipe_addr_q[PIPE_D-1];
  assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    pipe_vld_d    = pipe_vld_q << 1;
    pipe_vld_d[0] = issue && (GEN_LATENCY != 0);
  end

  always_comb begin
    in_flight   = '0;
    in_flight_d = '0;
    for (int i = 0; i < PIPE_D; i++) begin
      in_flight   = in_flight + CNT_W'(pipe_vld_q[i]);
      in_flight_d = in_flight_d + CNT_W'(pipe_vld_d[i]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_SWEEP;
      S_SWEEP: if (issue && issue_cnt_q == LAST_ADDR) state_d = S_DRAIN;
      // Leave as soon as the final write drains, so done follows it directly.
      S_DRAIN: if (in_flight_d == '0 && fifo_cnt_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_out = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    done_out = (state_q == S_DONE);
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    count_d     = count_q;
    if (state_q == S_IDLE && start_in) begin
      issue_cnt_d = '0;
      count_d     = '0;
    end else begin
      if (issue && issue_cnt_q != LAST_ADDR) issue_cnt_d = issue_cnt_q + 16'd1;
      if (pop && head_flag && count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      issue_cnt_q <= '0;
      count_q     <= '0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < PIPE_D; i++) pipe_addr_q[i] <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      count_q     <= count_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int i = PIPE_D - 1; i > 0; i--) pipe_addr_q[i] <= pipe_addr_q[i-1];
      pipe_addr_q[0] <= issue_cnt_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_flag_q[i] <= 1'b0;
      end
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= push_addr;
        fifo_flag_q[wr_ptr_q] <= bus.gen_data_in;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  assign bus.gen_addr_out  = issue_cnt_q;
  assign bus.bram_we_out   = pop;
  assign bus.bram_addr_out = fifo_empty ? 16'd0 : fifo_addr_q[rd_ptr_q];
  assign bus.bram_data_out = fifo_empty ? 1'b0 : head_flag;
  assign barrier_count_out = count_q;
endmodule
